// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, FSM state encoding and
// the datapath width.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: add/sub/and/or/mul, results wrap modulo 2^32,
// undefined opcodes produce zero.
import alu_pkg::*;

module alu_arbiter_alu (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  // Result selection by opcode
  always_comb begin
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_MUL:  res_o = a_i * b_i;
      default: res_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU, one transaction in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
import alu_pkg::*;

module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [2:0]        op0_i,
  input  logic [2:0]        op1_i,
  input  logic [DATA_W-1:0] a0_i,
  input  logic [DATA_W-1:0] b0_i,
  input  logic [DATA_W-1:0] a1_i,
  input  logic [DATA_W-1:0] b1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              id_o,
  input  logic              ack_i
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                win_q, win_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                valid_q, valid_d, id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                accept_s, pick_s, exec_done_s;
  logic [2:0]          sel_op_s;
  logic [DATA_W-1:0]   sel_a_s, sel_b_s, alu_res_s;

  assign accept_s    = (state_q == ST_IDLE) && (req0_i || req1_i);
  assign exec_done_s = (state_q == ST_EXEC) && (cnt_q == 4'd0);
  assign sel_op_s    = pick_s ? op1_i : op0_i;
  assign sel_a_s     = pick_s ? a1_i  : a0_i;
  assign sel_b_s     = pick_s ? b1_i  : b0_i;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // Winner selection: contention goes to the requester that did not win last
  always_comb begin
    if (req0_i && req1_i) begin
      pick_s = ~last_q;
    end else if (req1_i) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Last-winner next value
  always_comb begin
    if (accept_s) begin
      last_d = pick_s;
    end else begin
      last_d = last_q;
    end
  end

  // Last-winner register; reset to 1 so requester 0 wins the first contention
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Winner selection: requester 0 always has priority
  always_comb begin
    if (req0_i) begin
      pick_s = 1'b0;
    end else begin
      pick_s = req1_i;
    end
  end
`endif

  // FSM state and EXEC down-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; the counter holds the remaining EXEC cycles minus one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
          cnt_d   = is_mul(sel_op_s) ? MUL_LOAD : 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs and operand capture, computed one cycle ahead of the registers
  always_comb begin
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    win_d   = win_q;
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    if (accept_s) begin
      op_d   = sel_op_s;
      a_d    = sel_a_s;
      b_d    = sel_b_s;
      win_d  = pick_s;
      gnt0_d = ~pick_s;
      gnt1_d = pick_s;
    end else begin
      win_d = win_q;
    end
    if (exec_done_s) begin
      data_d  = alu_res_s;
      valid_d = 1'b1;
      id_d    = win_q;
    end else if ((state_q == ST_DONE) && ack_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output and latched-operand registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      op_q    <= 3'b000;
      a_q     <= {DATA_W{1'b0}};
      b_q     <= {DATA_W{1'b0}};
      win_q   <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  alu_arbiter_alu u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res_s)
  );

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign id_o    = id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, the number of EXEC cycles for a multiply (legal 1..15).
REQ-002 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_i/req1_i  input  1  request from requester 0/1, held high until its grant.
REQ-005 SHALL have ports op0_i/op1_i  input  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 mul, others undefined.
REQ-006 SHALL have ports a0_i, b0_i, a1_i, b1_i  input  32  operands, held stable with the request.
REQ-007 SHALL have ports gnt0_o/gnt1_o  output  1  one-cycle grant pulse: operands captured.
REQ-008 SHALL have port data_o  output  32  registered result.
REQ-009 SHALL have port valid_o  output  1  data_o/id_o valid; held until ack_i.
REQ-010 SHALL have port id_o  output  1  requester that owns the result.
REQ-011 SHALL have port ack_i  input  1  consumer accepts the result.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE, one transaction in flight.
REQ-013 SHALL, in IDLE with any req high, select a winner, latch its op/a/b, go to EXEC, and pulse the winner's gnt in the first EXEC cycle.
REQ-014 SHALL keep EXEC 1 cycle for ops other than 100, MUL_CYCLES cycles for 100, using a 4-bit down-counter.
REQ-015 SHALL, on the edge leaving EXEC, register the ALU result into data_o, set valid_o=1 and id_o=winner, enter DONE.
REQ-016 SHALL give all ops 32-bit results truncated modulo 2^32 (mul keeps low 32 bits); undefined ops give 0 with 1-cycle EXEC.
REQ-017 SHALL hold data_o/id_o/valid_o stable in DONE until ack_i is sampled high, then clear valid_o and return to IDLE.
REQ-018 SHALL ignore requests outside IDLE; earliest re-acceptance is the cycle after leaving DONE (non-mul throughput one result per 3 cycles).
REQ-019 SHALL hold data_o at its last value after valid_o falls.
REQ-020 SHALL ignore ack_i outside DONE.

Reset
REQ-021 SHALL, while rst_i is high, force state IDLE, counter 0, gnt0_o=gnt1_o=0, valid_o=0, id_o=0, data_o=0, last-winner register=1.
REQ-022 SHALL discard any in-flight transaction on reset; no grant or result is produced for it after release.

Configuration
REQ-023 SHALL use macro ALU_ARB_RR_EN: defined -> simultaneous requests resolve round-robin (winner = NOT last winner, last winner updated on each grant); undefined -> fixed priority, requester 0 always wins, last-winner register absent.
REQ-024 SHALL behave identically under both settings when only one requester is active.

Structure
REQ-025 SHALL take the op encodings (ADD, SUB, AND, OR, MUL) and the FSM state encoding from a shared package alu_pkg.
REQ-026 SHALL instantiate the existing ALU block as its single sub-module, fed from the latched operands, without modifying it.

Verification
REQ-027 SHALL test: req0=1, op=000, a=5, b=7 at IDLE -> gnt0_o pulse next cycle, valid_o=1 with data_o=12, id_o=0 one cycle later.
REQ-028 SHALL test: req1=1, op=100, a=0x10000, b=0x10000, MUL_CYCLES=2 -> valid_o 3 cycles after request sample, data_o=0, id_o=1.
REQ-029 SHALL test: req0 and req1 both held continuously with ALU_ARB_RR_EN, ack_i=1 -> grants alternate 0,1,0,1 from reset; without the macro -> grants 0,0,0,0.
REQ-030 SHALL test: result in DONE, ack_i=0 for 5 cycles -> data_o/id_o/valid_o stable; ack_i=1 -> valid_o=0 next cycle.
REQ-031 SHALL test: rst_i asserted mid-EXEC of a mul -> all outputs 0 immediately; no valid_o after release without a new request.
REQ-032 SHALL test: op=111, a=3, b=4 -> data_o=0 with 1-cycle EXEC latency; op=001, a=0, b=1 -> data_o=0xFFFFFFFF.
